// File: rtl/decode_ctrl.sv
// decode_ctrl: one-entry registered RV32I decode stage with a ready/valid
// handshake on both sides and a RUN/TRAP controller. The controller stops
// intake after an illegal instruction is loaded, until the trap handler
// acknowledges it.

// Immediate-format encodings. They are shared with imm_sel.vh consumers and
// guarded so an earlier definition takes precedence.
`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef U_TYPE
`define U_TYPE 3'd3
`endif
`ifndef J_TYPE
`define J_TYPE 3'd4
`endif

module decode_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_inst,
  output logic [2:0]  imm_sel,
  output logic        reg_wen,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        branch,
  output logic        jump,
  output logic        illegal,
  input  logic        flush,
  input  logic        trap_ack,
  output logic        trap_pending
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic        out_valid_reg;
  logic [24:0] out_inst_reg;
  logic [2:0]  imm_sel_reg;
  logic [4:0]  flags_reg;      // {reg_wen, mem_rd, mem_wr, branch, jump}
  logic        illegal_reg;

  logic [2:0]  dec_imm_sel;
  logic [4:0]  dec_flags;
  logic        dec_illegal;
  logic        load;

  // Intake is open only in RUN, not during a redirect, and when the slot is
  // free or being drained this cycle (full throughput).
  assign in_ready = (state_reg == RUN) && !flush && (!out_valid_reg || out_ready);
  assign load     = in_valid && in_ready;

  // Opcode decode of the incoming instruction.
  always_comb begin
    dec_imm_sel = `I_TYPE;
    dec_flags   = 5'b00000;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0110111: begin dec_imm_sel = `U_TYPE; dec_flags = 5'b10000; end // LUI
      7'b0010111: begin dec_imm_sel = `U_TYPE; dec_flags = 5'b10000; end // AUIPC
      7'b1101111: begin dec_imm_sel = `J_TYPE; dec_flags = 5'b10001; end // JAL
      7'b1100111: begin dec_imm_sel = `I_TYPE; dec_flags = 5'b10001; end // JALR
      7'b1100011: begin dec_imm_sel = `B_TYPE; dec_flags = 5'b00010; end // BRANCH
      7'b0000011: begin dec_imm_sel = `I_TYPE; dec_flags = 5'b11000; end // LOAD
      7'b0100011: begin dec_imm_sel = `S_TYPE; dec_flags = 5'b00100; end // STORE
      7'b0010011: begin dec_imm_sel = `I_TYPE; dec_flags = 5'b10000; end // OP-IMM
      7'b0110011: begin dec_imm_sel = `I_TYPE; dec_flags = 5'b10000; end // OP
      default:    dec_illegal = 1'b1;
    endcase
  end

  // Controller next state: enter TRAP when an illegal op is loaded, leave on
  // trap_ack; a flush always returns to RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (load && dec_illegal) state_next = TRAP;
      TRAP:    if (trap_ack) state_next = RUN;
      default: state_next = RUN;
    endcase
    if (flush) state_next = RUN;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // Decode entry: flush beats load, load beats consume, otherwise hold.
  // Payload fields keep their last value when the entry empties; only
  // out_valid and illegal drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_inst_reg  <= '0;
      imm_sel_reg   <= `I_TYPE;
      flags_reg     <= '0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_inst_reg  <= in_inst[31:7];
      imm_sel_reg   <= dec_imm_sel;
      flags_reg     <= dec_flags;
      illegal_reg   <= dec_illegal;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_inst     = out_inst_reg;
  assign imm_sel      = imm_sel_reg;
  assign reg_wen      = flags_reg[4];
  assign mem_rd       = flags_reg[3];
  assign mem_wr       = flags_reg[2];
  assign branch       = flags_reg[1];
  assign jump         = flags_reg[0];
  assign illegal      = illegal_reg;
  assign trap_pending = (state_reg == TRAP);

endmodule

// File: tb/tb_decode_ctrl.sv
// Testbench for decode_ctrl: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the decode slot.

`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef U_TYPE
`define U_TYPE 3'd3
`endif
`ifndef J_TYPE
`define J_TYPE 3'd4
`endif

module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_inst;
  logic [2:0]  imm_sel;
  logic        reg_wen, mem_rd, mem_wr, branch, jump;
  logic        illegal;
  logic        flush = 1'b0;
  logic        trap_ack = 1'b0;
  logic        trap_pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .imm_sel(imm_sel), .reg_wen(reg_wen),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump),
    .illegal(illegal), .flush(flush), .trap_ack(trap_ack),
    .trap_pending(trap_pending)
  );

  // Reference model: contents of the single decode slot plus trap flag.
  typedef struct {
    logic [2:0] imm;
    logic [4:0] flags;   // {reg_wen, mem_rd, mem_wr, branch, jump}
    logic       ill;
  } dec_t;

  logic        m_valid, m_trap, m_ill;
  logic [24:0] m_inst;
  logic [2:0]  m_imm;
  logic [4:0]  m_flags;

  logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                7'b0110011};

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d.imm = `I_TYPE; d.flags = 5'b0; d.ill = 1'b0;
    unique case (inst[6:0])
      7'b0110111, 7'b0010111: begin d.imm = `U_TYPE; d.flags = 5'b10000; end
      7'b1101111:             begin d.imm = `J_TYPE; d.flags = 5'b10001; end
      7'b1100111:             d.flags = 5'b10001;
      7'b1100011:             begin d.imm = `B_TYPE; d.flags = 5'b00010; end
      7'b0000011:             d.flags = 5'b11000;
      7'b0100011:             begin d.imm = `S_TYPE; d.flags = 5'b00100; end
      7'b0010011, 7'b0110011: d.flags = 5'b10000;
      default:                d.ill = 1'b1;
    endcase
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic ta);
    logic rdy;
    dec_t d;
    @(negedge clk);
    rst = r; in_valid = iv; in_inst = ins; out_ready = ordy; flush = fl; trap_ack = ta;
    #1;
    rdy = !m_trap && !fl && (!m_valid || ordy);
    if (!r) check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    if (r) begin
      m_valid = 0; m_inst = '0; m_imm = `I_TYPE; m_flags = '0; m_ill = 0; m_trap = 0;
    end else if (fl) begin
      m_valid = 0; m_ill = 0; m_trap = 0;
    end else begin
      if (m_trap && ta) m_trap = 0;
      if (iv && rdy) begin
        d = decode(ins);
        m_valid = 1; m_inst = ins[31:7]; m_imm = d.imm; m_flags = d.flags; m_ill = d.ill;
        if (d.ill) m_trap = 1;
      end else if (m_valid && ordy) begin
        m_valid = 0; m_ill = 0;
      end
    end
    @(posedge clk); #1;
    $display("cyc rst=%0b iv=%0b inst=%08h ordy=%0b fl=%0b ta=%0b -> ov=%0b imm=%0d fl=%05b ill=%0b tp=%0b",
             r, iv, ins, ordy, fl, ta, out_valid, imm_sel,
             {reg_wen, mem_rd, mem_wr, branch, jump}, illegal, trap_pending);
    check("out_valid",    {31'b0, out_valid},    {31'b0, m_valid});
    check("illegal",      {31'b0, illegal},      {31'b0, m_ill});
    check("trap_pending", {31'b0, trap_pending}, {31'b0, m_trap});
    check("out_inst",     {7'b0, out_inst},      {7'b0, m_inst});
    check("imm_sel",      {29'b0, imm_sel},      {29'b0, m_imm});
    check("flags", {27'b0, reg_wen, mem_rd, mem_wr, branch, jump}, {27'b0, m_flags});
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;

  initial begin
    m_valid = 0; m_trap = 0; m_ill = 0; m_inst = '0; m_imm = `I_TYPE; m_flags = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Back-to-back ADDI, JAL, SW at full throughput
    step(0, 1, ADDI, 1, 0, 0);
    check("b2b_imm_addi", {29'b0, imm_sel}, {29'b0, `I_TYPE});
    step(0, 1, JAL, 1, 0, 0);
    check("b2b_jump_jal", {31'b0, jump}, 32'd1);
    step(0, 1, SW, 1, 0, 0);
    check("b2b_memwr_sw", {31'b0, mem_wr}, 32'd1);
    step(0, 0, 0, 1, 0, 0);

    // Stall: BEQ held for 3 cycles with out_ready low
    step(0, 1, BEQ, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, ADDI, 0, 0, 0);
    check("stall_branch", {31'b0, branch}, 32'd1);
    check("stall_imm",    {29'b0, imm_sel}, {29'b0, `B_TYPE});
    step(0, 0, 0, 1, 0, 0);

    // Illegal instruction and trap
    step(0, 1, BAD, 1, 0, 0);
    step(0, 1, ADDI, 1, 0, 0);
    step(0, 1, ADDI, 1, 0, 0);
    step(0, 1, ADDI, 1, 0, 1);
    step(0, 1, ADDI, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Flush while an entry is held and a new one is offered
    step(0, 1, ADDI, 0, 0, 0);
    step(0, 1, JAL, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    // Reset while trapped with a valid entry
    step(0, 1, BAD, 0, 0, 0);
    step(1, 1, ADDI, 0, 0, 1);
    step(0, 1, ADDI, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 99) < 88) ins[6:0] = legal_ops[$urandom_range(0, 8)];
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, ins,
           $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
